comp_seq_ctrl: RTL
==================

// Module: comp_seq_ctrl
// PURPOSE
//   Sequencer that compares two WIDTH-bit unsigned operands using one external
//   2-bit comparator slice (comp2bit). It walks the operands MSB chunk first and
//   drives one chunk pair per cycle into the slice. It samples ahigher/alower/asame
//   and stops on the first unequal chunk, or after the last chunk. Results are
//   reported through a start/busy/done handshake.
// PARAMETERS
//   WIDTH   8   operand width; even, >= 2; NCHUNK = WIDTH/2 (localparam)
// PORTS
//   clk       in   1           system clock, rising edge
//   rst_n     in   1           asynchronous active-low reset
//   start     in   1           request; accepted only in IDLE
//   op_a      in   WIDTH       operand A, sampled at the accepting edge
//   op_b      in   WIDTH       operand B, sampled at the accepting edge
//   slice_a   out  [0:1]       chunk of A to comparator; bit 0 = chunk MSB
//   slice_b   out  [0:1]       chunk of B to comparator; bit 0 = chunk MSB
//   ahigher   in   1           comparator flag, slice_a > slice_b
//   alower    in   1           comparator flag, slice_a < slice_b
//   asame     in   1           comparator flag, slice_a == slice_b
//   busy      out  1           high in COMPARE and DONE
//   done      out  1           one-cycle pulse, result valid
//   a_gt      out  1           result A > B (held until next accept)
//   a_lt      out  1           result A < B (held)
//   a_eq      out  1           result A == B (held)
//   err       out  1           comparator flags not one-hot (held)
//   steps     out  clog2(NCHUNK)+1  chunks compared in last operation (held)
// BEHAVIOUR
//   Reset: state=IDLE; busy, done, a_gt, a_lt, a_eq, err, steps = 0; slice_a/b = 0;
//     operand regs = 0; chunk index = NCHUNK-1. Reset mid-operation aborts
//     immediately with no done pulse.
//   FSM IDLE -> COMPARE -> DONE -> IDLE.
//   IDLE: start=1 at edge -> latch op_a/op_b, idx<=NCHUNK-1, clear
//     a_gt/a_lt/a_eq/err/steps, go COMPARE. start=0 -> stay.
//   COMPARE: slice_a/b = latched chunk idx (bits 2*idx+1:2*idx), combinational from
//     regs; comparator flags are combinational, sampled the same cycle; steps+1.
//     - ahigher only -> a_gt<=1, go DONE
//     - alower only  -> a_lt<=1, go DONE
//     - asame only, idx==0 -> a_eq<=1, go DONE
//     - asame only, idx>0  -> idx<=idx-1, stay
//     - flags not exactly one-hot -> err<=1, results stay 0, go DONE
//   DONE: done=1 for exactly this cycle; next edge -> IDLE. start ignored here.
//   start during COMPARE/DONE: ignored, no queuing; op_a/op_b changes ignored.
//   slice_a/b = 0 outside COMPARE.
//   Latency: first mismatch in chunk k (k=0 is MSB chunk) -> done high in cycle
//     k+2 after the accepting edge, steps=k+1. Equal operands -> done in cycle
//     NCHUNK+1, steps=NCHUNK.
//   Back-to-back: next start is accepted no earlier than the cycle after DONE
//     (IDLE). Minimum period = 3 cycles.
//   Exactly one of a_gt/a_lt/a_eq/err is set after each done. All remain stable
//     until the next accepting edge.
// TESTING (WIDTH=8, bench models comp2bit behaviourally)
//   1 reset: rst_n=0 mid-COMPARE -> all outputs 0 asynchronously, IDLE, no done.
//   2 A=8'h9C, B=8'h5C -> mismatch on chunk 0 (10>01); done 2nd cycle after
//     accept, a_gt=1, steps=1.
//   3 A=8'h37, B=8'h3B -> chunks 00,11 equal; chunk 2 01<10; a_lt=1, steps=3.
//   4 A=B=8'hF0 -> a_eq=1, steps=4, done 5th cycle after accept; slice_a/b
//     sequence 11,11,00,00.
//   5 start pulsed in COMPARE with new operands -> ignored; result is for the
//     original pair. Then back-to-back start in the IDLE cycle -> accepted.
//   6 comparator stub forces ahigher=asame=1 on chunk 1 -> err=1,
//     a_gt=a_lt=a_eq=0, steps=2, done pulse.

Source files
------------

// File: rtl/comp_seq_ctrl.sv
// Sequencer that compares two unsigned operands one 2-bit chunk per cycle,
// MSB chunk first, using an external 2-bit comparator slice.
module comp_seq_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [WIDTH-1:0]             op_a,
    input  logic [WIDTH-1:0]             op_b,
    output logic [0:1]                   slice_a,
    output logic [0:1]                   slice_b,
    input  logic                         ahigher,
    input  logic                         alower,
    input  logic                         asame,
    output logic                         busy,
    output logic                         done,
    output logic                         a_gt,
    output logic                         a_lt,
    output logic                         a_eq,
    output logic                         err,
    output logic [$clog2(WIDTH/2):0]     steps
);

    localparam int unsigned NCHUNK  = WIDTH / 2;
    localparam int unsigned IDX_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned STEPS_W = $clog2(NCHUNK) + 1;

    typedef enum logic [1:0] {
        StIdle,
        StCompare,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               gt_q, gt_d;
    logic               lt_q, lt_d;
    logic               eq_q, eq_d;
    logic               err_q, err_d;
    logic [STEPS_W-1:0] steps_q, steps_d;

    logic [1:0] chunk_a;
    logic [1:0] chunk_b;
    logic [2:0] flags;

    // Select the current chunk; slice ports are [0:1] with bit 0 as chunk MSB.
    always_comb begin
        chunk_a = a_q[{idx_q, 1'b0} +: 2];
        chunk_b = b_q[{idx_q, 1'b0} +: 2];
        flags   = {ahigher, alower, asame};
        slice_a = 2'b00;
        slice_b = 2'b00;
        if (state_q == StCompare) begin
            slice_a[0] = chunk_a[1];
            slice_a[1] = chunk_a[0];
            slice_b[0] = chunk_b[1];
            slice_b[1] = chunk_b[0];
        end
    end

    // Next-state and datapath update for the IDLE -> COMPARE -> DONE sequence.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        err_d   = err_q;
        steps_d = steps_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    idx_d   = IDX_W'(NCHUNK - 1);
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    eq_d    = 1'b0;
                    err_d   = 1'b0;
                    steps_d = '0;
                    state_d = StCompare;
                end
            end
            StCompare: begin
                steps_d = steps_q + 1'b1;
                case (flags)
                    3'b100: begin
                        gt_d    = 1'b1;
                        state_d = StDone;
                    end
                    3'b010: begin
                        lt_d    = 1'b1;
                        state_d = StDone;
                    end
                    3'b001: begin
                        if (idx_q == '0) begin
                            eq_d    = 1'b1;
                            state_d = StDone;
                        end else begin
                            idx_d = idx_q - 1'b1;
                        end
                    end
                    // Comparator flags not one-hot: flag it and leave results clear.
                    default: begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end
                endcase
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= IDX_W'(NCHUNK - 1);
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            err_q   <= 1'b0;
            steps_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
            err_q   <= err_d;
            steps_q <= steps_d;
        end
    end

    // Status and held results come straight from registers.
    always_comb begin
        busy  = (state_q != StIdle);
        done  = (state_q == StDone);
        a_gt  = gt_q;
        a_lt  = lt_q;
        a_eq  = eq_q;
        err   = err_q;
        steps = steps_q;
    end

endmodule
